// File: rtl/mdu_controller_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// controller states and default latencies.
package md_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// The result is {hi, lo}; a zero divisor passes the current HI/LO through.
module mdu_arith
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    output logic [63:0] result
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] den_s;
    logic        [31:0] den_u;
    logic        [31:0] sq;
    logic        [31:0] sr;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic               b_zero;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
    assign a_mag  = a[31] ? -a : a;
    assign b_mag  = b[31] ? -b : b;
    assign b_zero = (b == 32'd0);
    assign den_s  = b_zero ? 32'd1 : b_mag;
    assign den_u  = b_zero ? 32'd1 : b;
    assign sq     = a_mag / den_s;
    assign sr     = a_mag % den_s;
    assign uq     = a / den_u;
    assign ur     = a % den_u;

    always_comb begin
        // NOTE: default first so every path assigns result and no latch is inferred.
        result = {hi_cur, lo_cur};
        case (md_op_e'(op))
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   if (!b_zero) result = {(a[31] ? -sr : sr), ((a[31] ^ b[31]) ? -sq : sq)};
            MD_DIVU:  if (!b_zero) result = {ur, uq};
            default:  result = {hi_cur, lo_cur};
        endcase
    end

endmodule

// File: rtl/mdu_controller.sv
// E-stage HI/LO sequencer: fixed-latency busy counter, result latch, HI/LO
// registers and the D-stage stall request.
module mdu_controller
    import md_defs::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        md_we,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        d_uses_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);

    md_state_e   state;
    md_state_e   state_next;
    md_op_e      op;
    logic [3:0]  count;
    logic [63:0] result_q;
    logic [63:0] arith_result;
    logic        accept_start;
    logic        write_md;
    logic        done;

    assign op           = md_op_e'(md_op);
    // md_we wins over start when both are seen.
    assign accept_start = start & ~md_we & ~flush & (state == ST_IDLE);
    assign write_md     = md_we & ~flush & (state == ST_IDLE);
    assign done         = (state == ST_BUSY) && (count == 4'd1);

    mdu_arith u_arith (
        .op     (md_op),
        .a      (rs_val),
        .b      (rt_val),
        .hi_cur (hi),
        .lo_cur (lo),
        .result (arith_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept_start) state_next = ST_BUSY;
            ST_BUSY: if (done)         state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_BUSY);
        md_stall = d_uses_md & ((state == ST_BUSY) | accept_start);
    end

    // NOTE: the result latch is a plain register and is reset like HI/LO, so a
    // reset mid-operation can never leak a stale product afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= 4'd0;
            result_q <= 64'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            if (accept_start) begin
                result_q <= arith_result;
                count    <= is_div(op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end else if (state == ST_BUSY) begin
                count <= count - 4'd1;
            end

            if (done) begin
                hi <= result_q[63:32];
                lo <= result_q[31:0];
            end else if (write_md) begin
                if (op == MD_MTHI) hi <= rs_val;
                if (op == MD_MTLO) lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_mdu_controller.sv
// Scoreboard bench for mdu_controller: stimulus pushes expected HI/LO and
// latency, a monitor pops and compares whenever busy falls.
module tb_mdu_controller;
    import md_defs::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        md_we;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        d_uses_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    typedef struct {
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu_controller #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .md_we     (md_we),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush     (flush),
        .d_uses_md (d_uses_md),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .md_stall  (md_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Behavioural reference: plain 64-bit arithmetic on the operands.
    function automatic logic [63:0] ref_result(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT:  return 64'(sa * sb_);
            MD_MULTU: return 64'(ua * ub);
            MD_DIV: begin
                if (b == 32'd0) return {model_hi, model_lo};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {model_hi, model_lo};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {model_hi, model_lo};
        endcase
    endfunction

    // Monitor: measures each busy run and compares HI/LO when it ends.
    int   run_len = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        sb_entry_t e;
        if (reset) begin
            run_len   = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                run_len++;
                if (d_uses_md) check("stall_busy", 64'(md_stall), 64'd1);
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("busy_cycles", 64'(run_len), 64'(e.exp_cycles));
                    check("hi", 64'(hi), 64'(e.exp_hi));
                    check("lo", 64'(lo), 64'(e.exp_lo));
                end
                run_len = 0;
            end
            if (!d_uses_md) check("no_stall", 64'(md_stall), 64'd0);
            prev_busy = busy;
        end
    end

    always @(posedge clk) begin
        if (!reset && busy) begin
            assert (!(start && !flush)) else $error("start issued while busy");
            assert (!(md_we && !flush)) else $error("md_we issued while busy");
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
    endtask

    // Issues one operation; flush_at>0 raises flush on that busy cycle.
    task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic uses, input int flush_at);
        logic [63:0] r;
        bit          is_md;
        is_md = (op == MD_MTHI) || (op == MD_MTLO);
        if (!is_md) begin
            r = ref_result(op, a, b);
            sb.push_back('{exp_hi: r[63:32], exp_lo: r[31:0],
                           exp_cycles: ((op == MD_DIV) || (op == MD_DIVU)) ? DC : MC});
            model_hi = r[63:32];
            model_lo = r[31:0];
        end
        @(posedge clk); #1;
        md_op = op; rs_val = a; rt_val = b; d_uses_md = uses;
        if (is_md) md_we = 1'b1;
        else       start = 1'b1;
        @(negedge clk);
        if (!is_md && uses) check("stall_start", 64'(md_stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0; md_we = 1'b0; md_op = MD_NONE;
        if (is_md) begin
            if (op == MD_MTHI) model_hi = a;
            else               model_lo = a;
            check("mt_hi", 64'(hi), 64'(model_hi));
            check("mt_lo", 64'(lo), 64'(model_lo));
        end else begin
            if (flush_at > 0) begin
                repeat (flush_at - 1) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
            end
            wait_idle();
        end
        d_uses_md = 1'b0;
    endtask

    initial begin
        md_op_e ops[6] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
        reset = 1'b1; start = 1'b0; md_op = MD_NONE; md_we = 1'b0;
        rs_val = 32'd0; rt_val = 32'd0; flush = 1'b0; d_uses_md = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        do_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0, 0);
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_op(MD_MTHI,  32'd5, 32'd0, 1'b1, 0);
        do_op(MD_MTLO,  32'd6, 32'd0, 1'b0, 0);
        do_op(MD_DIVU,  32'h1234_5678, 32'd0, 1'b1, 0);
        do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(MD_MTHI,  32'h1234_5678, 32'd0, 1'b0, 0);

        // Flushed start is cancelled.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; md_op = MD_MULT; rs_val = 32'd7; rt_val = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; md_op = MD_NONE;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'(model_hi));
        check("flush_lo", 64'(lo), 64'(model_lo));

        // Flush on the 3rd busy cycle does not cancel an issued mult.
        do_op(MD_MULT, 32'h0001_0003, 32'hFFFF_0005, 1'b1, 3);

        // Asynchronous reset on the 4th cycle of a div.
        @(posedge clk); #1;
        start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        sb.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        do_op(MD_MULT, 32'd12345, 32'hFFFF_FF00, 1'b1, 0);

        // Randomised mix against the reference model.
        for (int i = 0; i < 30; i++) begin
            md_op_e      op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 5)];
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            do_op(op, a, b, 1'($urandom_range(0, 1)), 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("final_hi", 64'(hi), 64'(model_hi));
        check("final_lo", 64'(lo), 64'(model_lo));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
